// File: rtl/value_to_pay_calc_if.sv
// rtl/value_to_pay_calc_if.sv - client/button inputs and price outputs of the price calculator
// master drives selections and buttons; slave is the calculator.
interface value_to_pay_calc_if;
  logic       clientA;
  logic       clientB;
  logic       timeButton;
  logic       confirmButton;
  logic       cancelButton;
  logic [4:0] valueToPay;
  logic       valueValid;
  logic       busy;

  modport master (
    output clientA, clientB, timeButton, confirmButton, cancelButton,
    input  valueToPay, valueValid, busy
  );

  modport slave (
    input  clientA, clientB, timeButton, confirmButton, cancelButton,
    output valueToPay, valueValid, busy
  );
endinterface

// File: rtl/value_to_pay_calc.sv
// rtl/value_to_pay_calc.sv - latches a client, counts time units, registers a confirmed price
// All outputs are registered; button inputs act on their rising edge only.
module value_to_pay_calc #(
  parameter int RATE_A      = 2,
  parameter int RATE_B      = 4,
  parameter int MAX_UNITS_A = 8,
  parameter int MAX_UNITS_B = 7
) (
  input logic                clk,
  input logic                reset,
  value_to_pay_calc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] RATE_A5 = 5'(RATE_A);
  localparam logic [4:0] RATE_B5 = 5'(RATE_B);
  localparam logic [3:0] MAX_A4  = 4'(MAX_UNITS_A);
  localparam logic [3:0] MAX_B4  = 4'(MAX_UNITS_B);

  state_t     state;
  logic [3:0] units;
  logic       clientSel;
  logic       timeQ;
  logic       confirmQ;
  logic       cancelQ;

  logic       timeEdge;
  logic       confirmEdge;
  logic       cancelEdge;
  logic [3:0] maxUnits;
  logic [4:0] price;

  assign timeEdge    = bus.timeButton    & ~timeQ;
  assign confirmEdge = bus.confirmButton & ~confirmQ;
  assign cancelEdge  = bus.cancelButton  & ~cancelQ;

  always_comb begin
    maxUnits = clientSel ? MAX_B4 : MAX_A4;
    price    = (clientSel ? RATE_B5 : RATE_A5) * {1'b0, units};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      units          <= 4'd0;
      clientSel      <= 1'b0;
      // History starts high so a button held through reset release does not fire.
      timeQ          <= 1'b1;
      confirmQ       <= 1'b1;
      cancelQ        <= 1'b1;
      bus.valueToPay <= 5'd0;
      bus.valueValid <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      timeQ    <= bus.timeButton;
      confirmQ <= bus.confirmButton;
      cancelQ  <= bus.cancelButton;

      case (state)
        IDLE: begin
          if (timeEdge && (bus.clientA ^ bus.clientB)) begin
            clientSel <= bus.clientB;
            units     <= 4'd1;
            state     <= COUNT;
            bus.busy  <= 1'b1;
          end
        end

        COUNT: begin
          // cancel outranks confirm, which outranks another time unit
          if (cancelEdge) begin
            state    <= IDLE;
            units    <= 4'd0;
            bus.busy <= 1'b0;
          end else if (confirmEdge) begin
            state          <= DONE;
            bus.valueToPay <= price;
            bus.valueValid <= 1'b1;
            bus.busy       <= 1'b0;
          end else if (timeEdge && (units < maxUnits)) begin
            units <= units + 4'd1;
          end
        end

        DONE: begin
          if (cancelEdge || confirmEdge) begin
            state          <= IDLE;
            units          <= 4'd0;
            bus.valueToPay <= 5'd0;
            bus.valueValid <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          units          <= 4'd0;
          bus.valueToPay <= 5'd0;
          bus.valueValid <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_value_to_pay_calc.sv
// tb/tb_value_to_pay_calc.sv - directed scoreboard bench for value_to_pay_calc
module tb_value_to_pay_calc;

  localparam int RATE_A      = 2;
  localparam int RATE_B      = 4;
  localparam int MAX_UNITS_A = 8;
  localparam int MAX_UNITS_B = 7;

  logic clk = 1'b0;
  logic reset;

  value_to_pay_calc_if vif ();

  value_to_pay_calc #(
    .RATE_A     (RATE_A),
    .RATE_B     (RATE_B),
    .MAX_UNITS_A(MAX_UNITS_A),
    .MAX_UNITS_B(MAX_UNITS_B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] value;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   passCount  = 0;
  int   totalCount = 0;

  function automatic logic [4:0] priceOf(input logic isB, input int presses);
    int u;
    u = isB ? ((presses > MAX_UNITS_B) ? MAX_UNITS_B : presses)
            : ((presses > MAX_UNITS_A) ? MAX_UNITS_A : presses);
    return 5'((isB ? RATE_B : RATE_A) * u);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic [4:0] v, input logic vv, input logic b);
    exp_t e;
    e.tag = tag; e.value = v; e.valid = vv; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic checkOut();
    exp_t e;
    logic [6:0] obs;
    logic [6:0] req;
    e   = sb.pop_front();
    obs = {vif.valueToPay, vif.valueValid, vif.busy};
    req = {e.value, e.valid, e.busy};
    totalCount++;
    assert (obs === req) passCount++;
    else $error("FAIL %s: observed value=%0d valid=%b busy=%b, expected value=%0d valid=%b busy=%b",
                e.tag, vif.valueToPay, vif.valueValid, vif.busy, e.value, e.valid, e.busy);
  endtask

  task automatic timePulses(input int n);
    for (int i = 0; i < n; i++) begin
      vif.timeButton = 1'b1; tick();
      vif.timeButton = 1'b0; tick();
    end
  endtask

  task automatic confirmPress(input string tag, input logic [4:0] v);
    expectOut(tag, v, 1'b1, 1'b0);
    vif.confirmButton = 1'b1; tick();
    checkOut();
    vif.confirmButton = 1'b0; tick();
  endtask

  task automatic cancelPress(input string tag);
    expectOut(tag, 5'd0, 1'b0, 1'b0);
    vif.cancelButton = 1'b1; tick();
    checkOut();
    vif.cancelButton = 1'b0; tick();
  endtask

  initial begin
    vif.clientA = 1'b1; vif.clientB = 1'b0;
    vif.timeButton = 1'b1; vif.confirmButton = 1'b1; vif.cancelButton = 1'b1;
    reset = 1'b1;
    tick(); tick();
    expectOut("reset_state", 5'd0, 1'b0, 1'b0);
    checkOut();

    // Release reset with everything still held: nothing may fire.
    reset = 1'b0;
    tick(); tick();
    expectOut("held_through_reset", 5'd0, 1'b0, 1'b0);
    checkOut();
    vif.timeButton = 1'b0; vif.confirmButton = 1'b0; vif.cancelButton = 1'b0;
    vif.clientA = 1'b0;
    tick();

    // Client A, 3 units.
    vif.clientA = 1'b1;
    timePulses(1);
    expectOut("a3_busy", 5'd0, 1'b0, 1'b1);
    checkOut();
    timePulses(2);
    confirmPress("a3_price", priceOf(1'b0, 3));
    expectOut("a3_held", priceOf(1'b0, 3), 1'b1, 1'b0);
    checkOut();
    timePulses(1);
    expectOut("a3_time_in_done", priceOf(1'b0, 3), 1'b1, 1'b0);
    checkOut();
    cancelPress("a3_cancel");

    // Client B saturation, then confirm from DONE clears.
    vif.clientA = 1'b0; vif.clientB = 1'b1;
    timePulses(9);
    confirmPress("b9_sat", priceOf(1'b1, 9));
    expectOut("b9_confirm_clear", 5'd0, 1'b0, 1'b0);
    vif.confirmButton = 1'b1; tick();
    checkOut();
    vif.confirmButton = 1'b0; tick();

    // Client A saturation.
    vif.clientA = 1'b1; vif.clientB = 1'b0;
    timePulses(10);
    confirmPress("a10_sat", priceOf(1'b0, 10));
    cancelPress("a10_cancel");

    // Both clients: ignored; then A alone latches; B toggling does nothing.
    vif.clientA = 1'b1; vif.clientB = 1'b1;
    timePulses(1);
    expectOut("both_clients_idle", 5'd0, 1'b0, 1'b0);
    checkOut();
    vif.clientB = 1'b0;
    timePulses(1);
    expectOut("single_client_count", 5'd0, 1'b0, 1'b1);
    checkOut();
    vif.clientA = 1'b0; vif.clientB = 1'b1; tick();
    vif.clientB = 1'b0; tick();
    vif.clientB = 1'b1; tick();
    confirmPress("latched_a_1unit", priceOf(1'b0, 1));
    cancelPress("latch_cancel");

    // All three edges together: cancel wins.
    vif.clientA = 1'b1; vif.clientB = 1'b0;
    timePulses(2);
    expectOut("all_edges_cancel", 5'd0, 1'b0, 1'b0);
    vif.timeButton = 1'b1; vif.confirmButton = 1'b1; vif.cancelButton = 1'b1;
    tick();
    checkOut();
    vif.timeButton = 1'b0; vif.confirmButton = 1'b0; vif.cancelButton = 1'b0;
    tick();

    // Confirm with time together: confirm wins, 2 units priced.
    timePulses(2);
    expectOut("confirm_over_time", priceOf(1'b0, 2), 1'b1, 1'b0);
    vif.timeButton = 1'b1; vif.confirmButton = 1'b1;
    tick();
    checkOut();
    vif.timeButton = 1'b0; vif.confirmButton = 1'b0;
    tick();
    cancelPress("cot_cancel");

    // Reset while DONE holds 20.
    vif.clientA = 1'b0; vif.clientB = 1'b1;
    timePulses(5);
    confirmPress("b5_price", priceOf(1'b1, 5));
    reset = 1'b1;
    expectOut("reset_in_done", 5'd0, 1'b0, 1'b0);
    tick();
    checkOut();
    reset = 1'b0;
    expectOut("after_reset", 5'd0, 1'b0, 1'b0);
    tick();
    checkOut();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
